// File: rtl/booth_pkg.sv
// Shared encodings for the radix-2 Booth sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mul_seq_addsub.sv
// Add/subtract unit: y = a + b (mode=0) or a - b (mode=1), result modulo 2^w.
module booth_mul_seq_addsub #(
    parameter int w = 6
) (
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    input  logic         mode,
    output logic [w-1:0] y
);

    // Subtraction is two's complement: invert b and inject carry-in; carry-out is dropped.
    assign y = a + (b ^ {w{mode}}) + w'(mode);

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed multiplier, radix-2 Booth recoding, one add/sub/shift step per clock.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int size = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [size-1:0]   multiplicand,
    input  logic [size-1:0]   multiplier,
    output logic              busy,
    output logic              done,
    output logic [2*size-1:0] product,
    output logic [1:0]        state_dbg
);

    // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE);
    // busy stays high for exactly size cycles, then done pulses for one cycle
    // with product valid. start while busy=1 is ignored.

    localparam int cw = $clog2(size + 1);

    state_t            state, state_next;
    logic [size:0]     m_reg;
    logic [size:0]     a_reg;
    logic [size-1:0]   q_reg;
    logic              q_m1;
    logic [cw-1:0]     count;

    logic [1:0]        pair;
    logic              mode;
    logic [size:0]     as_y;
    logic [size:0]     a_next;
    logic [2*size+1:0] sh;
    logic              load;
    logic              last;

    assign pair  = {q_reg[0], q_m1};
    assign mode  = (pair == BOOTH_SUB);
    assign load  = start && (state != RUN);
    assign last  = (state == RUN) && (count == cw'(1));

    booth_mul_seq_addsub #(.w(size + 1)) u_addsub (
        .a    (a_reg),
        .b    (m_reg),
        .mode (mode),
        .y    (as_y)
    );

    assign a_next = (pair == BOOTH_ADD || pair == BOOTH_SUB) ? as_y : a_reg;

    // New {A, Q, q_m1}: arithmetic right shift of {A', Q, q_m1}.
    assign sh = {a_next[size], a_next, q_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == cw'(1)) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (load) begin
            m_reg <= {multiplicand[size-1], multiplicand};
            a_reg <= '0;
            q_reg <= multiplier;
            q_m1  <= 1'b0;
            count <= cw'(size);
        end else if (state == RUN) begin
            a_reg <= sh[2*size+1:size+1];
            q_reg <= sh[size:1];
            q_m1  <= sh[0];
            count <= count - cw'(1);
            if (last) begin
                product <= sh[2*size:1];
            end
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq (size=5) with a product scoreboard queue.
module tb_booth_mul_seq;

    localparam int size = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic [size-1:0]   multiplicand;
    logic [size-1:0]   multiplier;
    logic              busy;
    logic              done;
    logic [2*size-1:0] product;
    logic [1:0]        state_dbg;

    logic [2*size-1:0] exp_q[$];
    int total;
    int bad;

    booth_mul_seq #(.size(size)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2*size-1:0] model(input logic [size-1:0] m, input logic [size-1:0] q);
        logic signed [2*size-1:0] ms;
        logic signed [2*size-1:0] qs;
        ms = {{size{m[size-1]}}, m};
        qs = {{size{q[size-1]}}, q};
        return ms * qs;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: called at a negedge, returns at the negedge after the load edge
    task automatic do_start(input logic [size-1:0] m, input logic [size-1:0] q, input bit push);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        if (push) exp_q.push_back(model(m, q));
        @(negedge clk);
        start = 1'b0;
    endtask

    // waits for done; 'already' is the number of negedges consumed since do_start returned
    task automatic wait_result(input string tag, input int already);
        int n;
        int busy_cnt;
        logic [2*size-1:0] exp_p;
        n = 0;
        busy_cnt = already;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(size - already));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(size));
        if (exp_q.size() > 0) begin
            exp_p = exp_q.pop_front();
            check({tag, "_product"}, 32'(product), 32'(exp_p));
        end else begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end
    endtask

    initial begin
        logic [2*size-1:0] held;
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'h000);
        check("reset_state", 32'(state_dbg), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("idle_no_done", 32'(done), 32'd0);
        end

        // 3 * 5 = 15, then product held in IDLE
        do_start(5'd3, 5'd5, 1'b1);
        wait_result("m3_q5", 0);
        check("m3_q5_const", 32'(product), 32'h00F);
        @(negedge clk);
        check("done_one_pulse", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("product_held", 32'(product), 32'h00F);

        do_start(5'h1D, 5'd5, 1'b1);
        wait_result("mneg3_q5", 0);
        check("mneg3_q5_const", 32'(product), 32'h3F1);
        @(negedge clk);

        do_start(5'd15, 5'h10, 1'b1);
        wait_result("m15_qneg16", 0);
        check("m15_qneg16_const", 32'(product), 32'h310);
        @(negedge clk);

        do_start(5'h10, 5'h10, 1'b1);
        wait_result("mneg16_qneg16", 0);
        check("mneg16_qneg16_const", 32'(product), 32'h100);
        @(negedge clk);

        do_start(5'd0, 5'h19, 1'b1);
        wait_result("m0_qneg7", 0);
        @(negedge clk);

        // random operands
        for (int i = 0; i < 6; i++) begin
            do_start(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);
            wait_result("random", 0);
            @(negedge clk);
        end

        // start during RUN must be ignored
        do_start(5'd4, 5'd6, 1'b1);
        @(negedge clk);
        multiplicand = 5'd7;
        multiplier = 5'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result("run_start_ignored", 2);
        @(negedge clk);

        // back-to-back: reload during DONE
        do_start(5'd3, 5'd3, 1'b1);
        wait_result("b2b_first", 0);
        held = product;
        do_start(5'd2, 5'h1E, 1'b1);
        check("b2b_reload_busy", 32'(busy), 32'd1);
        check("b2b_product_stable", 32'(product), 32'(held));
        wait_result("b2b_second", 0);
        check("b2b_second_const", 32'(product), 32'h3FC);
        @(negedge clk);

        // reset on the 3rd RUN cycle abandons the operation
        do_start(5'd5, 5'd5, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_product", 32'(product), 32'h000);
        check("midrst_state", 32'(state_dbg), 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 32'd0);
        end
        do_start(5'd7, 5'd7, 1'b1);
        wait_result("after_rst_m7_q7", 0);
        check("after_rst_const", 32'(product), 32'h031);
        @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential signed multiplier using radix-2 Booth recoding; one add/subtract/shift iteration per clock.
- Arithmetic counterpart of the non-restoring divider. Shares its operand width convention and its ripple add/subtract datapath style.
- Sits beside the divider in the arithmetic unit.
- Start/done handshake toward the controlling FSM.

Parameters:
- size, 5, operand width in bits. Both operands are two's complement; product is 2*size bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- multiplicand  input  size  signed operand M; sampled with start
- multiplier  input  size  signed operand Q; sampled with start
- busy  output  1  high while iterations run
- done  output  1  one-cycle pulse; product valid
- product  output  2*size  signed result; held until next accepted start or rst

Behaviour:
- Reset: synchronous, active-high, on rising clk. Forces state=IDLE, busy=0, done=0, product=0, A=0, Q=0, q_m1=0, count=0. Reset mid-operation abandons the computation; no done pulse is produced.
- States:
  - IDLE: waits for start.
  - RUN: performs iterations.
  - DONE: one cycle, done=1.
- Transitions:
  - IDLE -> RUN when start=1.
  - RUN -> RUN while count>1.
  - RUN -> DONE on the edge where count goes 1 -> 0.
  - DONE -> RUN if start=1, otherwise DONE -> IDLE.
  - start is ignored in RUN.
- Load edge (start accepted):
  - M_reg <= multiplicand, sign-extended to size+1 bits.
  - A <= 0 (size+1 bits).
  - Q <= multiplier.
  - q_m1 <= 0.
  - count <= size.
  - busy <= 1, done <= 0.
- Each RUN edge:
  - Examine {Q[0], q_m1}:
    - 01: A' = A + M_reg.
    - 10: A' = A - M_reg.
    - 00 / 11: A' = A.
  - Then arithmetic shift right of {A', Q, q_m1} by one, replicating A'[size].
  - count decrements.
- A is size+1 bits so that M = -2^(size-1) never overflows.
- Add/subtract is one add/subtract unit: mode=1 inverts the B input and injects carry-in 1. Its carry-out is discarded; the result is taken modulo 2^(size+1).
- Final RUN edge:
  - product <= low 2*size bits of {A, Q} after the shift.
  - busy <= 0, done <= 1.
- Latency: done is high in the cycle beginning exactly size clocks after the load edge. busy is high for exactly size cycles.
- Throughput: back-to-back operation is allowed by asserting start during the DONE cycle.
- product changes only on the final RUN edge or on reset. It is stable through IDLE and the following RUN.
- Full range is exact. (-2^(size-1)) * (-2^(size-1)) = 2^(2*size-2) fits in 2*size signed bits.
- A zero operand still takes size cycles; there is no early termination.

Decomposition:
- Shared package/header booth_pkg:
  - State encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Booth decode constants BOOTH_ADD=2'b01, BOOTH_SUB=2'b10.
- One natural sub-module: the existing AddSub add/subtract unit, instantiated with size+1.
  - mode = (Booth pair == BOOTH_SUB).
  - Its output is used only when the pair is 01 or 10.
- Counter width is $clog2(size+1).
- Controller FSM and shift register stay in booth_mul_seq.

Test Plan (size=5):
- rst held 2 cycles, then released -> busy=0, done=0, product=10'h000. No done pulse without start.
- start with M=3, Q=5 -> busy high 5 cycles; done pulses once in the 6th cycle after the load edge; product=10'h00F (15), held afterward.
- M=-3 (5'h1D), Q=5 -> product=10'h3F1 (-15). M=15, Q=-16 (5'h10) -> product=10'h310 (-240).
- M=-16, Q=-16 -> product=10'h100 (256), checking A sign-extension. M=0, Q=-7 -> product=0 after full 5 cycles.
- start pulsed during RUN with new operands -> ignored; result reflects the original operands. start asserted in the DONE cycle with M=2, Q=-2 -> immediate reload; next product=10'h3FC.
- rst asserted on the 3rd RUN cycle -> next cycle busy=0, done=0, product=0, state IDLE. A subsequent start of 7*7 gives product=10'h031.
